// File: rtl/counter_mod_updown.sv
// Modulo up/down counter with runtime terminal value, parallel load and a registered wrap pulse.
// Define COUNTER_SAT_EN to saturate at 0 / max_val instead of wrapping (wrap is then always 0).
module counter_mod_updown #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] q,
  output logic             is_all_zero,
  output logic             is_max,
  output logic             wrap
);

`ifdef COUNTER_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  localparam logic [WIDTH-1:0] One    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ResetQ = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      if (up) begin
        if (count_q < max_val) begin
          count_d = count_q + One;
        end else if (SatEn) begin
          count_d = max_val;
        end else begin
          // Also covers a count left above a freshly lowered max_val.
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (count_q > max_val) begin
          count_d = max_val;
        end else if (count_q != '0) begin
          count_d = count_q - One;
        end else if (SatEn) begin
          count_d = '0;
        end else begin
          count_d = max_val;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= ResetQ;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign q           = count_q;
  assign wrap        = wrap_q;
  assign is_all_zero = (count_q == '0);
  assign is_max      = (count_q == max_val);

endmodule

// File: tb/tb_counter_mod_updown.sv
// Self-checking bench: two counters (RESET_VAL 0 and 3) against an arithmetic reference model,
// plus hand-computed scenario checks.
module tb_counter_mod_updown;

  logic       clk;
  logic       clr, en, up, load;
  logic [3:0] load_val, max_val;
  logic [3:0] q0, q3;
  logic       z0, z3, m0, m3, w0, w3;

  int total = 0;
  int bad   = 0;

  int unsigned mq0, mq3;
  bit          mw0, mw3;
  bit          mvalid = 0;

  counter_mod_updown #(.WIDTH(4), .RESET_VAL(0)) dut0 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .max_val(max_val), .q(q0), .is_all_zero(z0), .is_max(m0), .wrap(w0)
  );

  counter_mod_updown #(.WIDTH(4), .RESET_VAL(3)) dut3 (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .max_val(max_val), .q(q3), .is_all_zero(z3), .is_max(m3), .wrap(w3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour expressed directly from the counting rules.
  task automatic model_step(input int unsigned rv, inout int unsigned mq, inout bit mw);
    int unsigned mv, lv;
    mv = max_val;
    lv = load_val;
    mw = 0;
    if (clr) begin
      mq = rv;
    end else if (load) begin
      mq = (lv < mv) ? lv : mv;
    end else if (en) begin
`ifdef COUNTER_SAT_EN
      if (up) mq = (mq + 1 <= mv) ? mq + 1 : mv;
      else if (mq > mv) mq = mv;
      else if (mq > 0) mq = mq - 1;
`else
      if (up) begin
        if (mq < mv) mq = mq + 1;
        else begin mq = 0; mw = 1; end
      end else begin
        if (mq == 0) begin mq = mv; mw = 1; end
        else if (mq > mv) mq = mv;
        else mq = mq - 1;
      end
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0, mq0, mw0);
    model_step(3, mq3, mw3);
    if (clr) mvalid = 1;
    #2;
  endtask

  task automatic drive(input bit c, input bit l, input bit e, input bit u,
                       input int lv, input int mv);
    clr = c; load = l; en = e; up = u;
    load_val = 4'(lv);
    max_val  = 4'(mv);
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      check("cmp_q0", q0, mq0);
      check("cmp_wrap0", w0, mw0);
      check("cmp_zero0", z0, mq0 == 0);
      check("cmp_max0", m0, mq0 == max_val);
      check("cmp_q3", q3, mq3);
      check("cmp_wrap3", w3, mw3);
      check("cmp_zero3", z3, mq3 == 0);
      check("cmp_max3", m3, mq3 == max_val);
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 9);
    repeat (2) @(posedge clk);
    #2;
    drive(1, 0, 0, 0, 0, 9);
    tick();
    check("reset_q0", q0, 0);
    check("reset_q3", q3, 3);
    check("reset_wrap", w0, 0);

`ifndef COUNTER_SAT_EN
    drive(0, 0, 1, 1, 0, 9);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("up_seq_q", q0, k % 10);
      check("up_seq_wrap", w0, k == 10);
      check("up_seq_is_max", m0, k == 9);
    end
    drive(0, 0, 0, 0, 0, 9);
    tick();
    check("hold_wrap_clear", w0, 0);
    check("hold_q", q0, 0);

    drive(0, 0, 1, 0, 0, 9);
    tick();
    check("down_wrap_q", q0, 9);
    check("down_wrap_pulse", w0, 1);
    tick();
    check("down_step_q", q0, 8);
    check("down_step_wrap", w0, 0);

    drive(0, 1, 1, 1, 12, 9);
    tick();
    check("load_clamp_q", q0, 9);
    check("load_clamp_wrap", w0, 0);

    drive(0, 1, 0, 0, 7, 9);
    tick();
    drive(0, 0, 1, 1, 0, 5);
    tick();
    check("lower_max_up_q", q0, 0);
    check("lower_max_up_wrap", w0, 1);
    drive(0, 1, 0, 0, 7, 9);
    tick();
    drive(0, 0, 1, 0, 0, 5);
    tick();
    check("lower_max_down_q", q0, 5);
    check("lower_max_down_wrap", w0, 0);

    drive(0, 1, 0, 0, 9, 9);
    tick();
    drive(1, 0, 1, 1, 0, 9);
    tick();
    check("clr_wins_q0", q0, 0);
    check("clr_wins_q3", q3, 3);
    check("clr_wins_wrap", w0, 0);

    drive(0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("max0_up_q", q0, 0);
      check("max0_up_wrap", w0, 1);
    end
    drive(0, 0, 1, 0, 0, 0);
    tick();
    check("max0_down_wrap", w0, 1);
    check("max0_zero", z0, 1);
`else
    drive(0, 0, 1, 1, 0, 15);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("sat_up_wrap", w0, 0);
    end
    check("sat_up_q", q0, 15);
    drive(0, 0, 1, 0, 0, 15);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("sat_down_wrap", w0, 0);
    end
    check("sat_down_q", q0, 0);
    check("sat_down_zero", z0, 1);
`endif

    // Randomized phase; the negedge compare process does the checking.
    drive(0, 0, 0, 0, 0, $urandom_range(15));
    for (int i = 0; i < 3000; i++) begin
      clr  = ($urandom_range(31) == 0);
      load = ($urandom_range(7) == 0);
      en   = ($urandom_range(3) != 0);
      up   = $urandom_range(1);
      load_val = 4'($urandom_range(15));
      if ($urandom_range(15) == 0) max_val = 4'($urandom_range(15));
      tick();
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_mod_updown.md
COUNTER_MOD_UPDOWN -- requirements
Module: counter_mod_updown

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, counter bit width (legal 2..32).
REQ-002 The module SHALL have parameter RESET_VAL, default 0, value loaded into q on reset (must be <= 2^WIDTH-1).
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The module SHALL have port clr  input  1  reset, synchronous and active-high.
REQ-005 The module SHALL have port en  input  1  count enable (1 = step, 0 = hold).
REQ-006 The module SHALL have port up  input  1  direction (1 = increment, 0 = decrement), sampled only when en=1.
REQ-007 The module SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 The module SHALL have port load_val  input  WIDTH  value for load.
REQ-009 The module SHALL have port max_val  input  WIDTH  runtime terminal value; count range is 0..max_val.
REQ-010 The module SHALL have port q  output  WIDTH  registered count.
REQ-011 The module SHALL have port is_all_zero  output  1  combinational, q == 0.
REQ-012 The module SHALL have port is_max  output  1  combinational, q == max_val.
REQ-013 The module SHALL have port wrap  output  1  registered one-cycle pulse, asserted in the cycle after q wrapped (either direction).

Function
REQ-014 Per rising edge, priority SHALL be clr > load > en; lower-priority inputs are ignored that cycle.
REQ-015 load=1 SHALL set q to min(load_val, max_val) next cycle; wrap=0.
REQ-016 en=1, up=1, q < max_val SHALL set q to q+1; wrap=0.
REQ-017 en=1, up=1, q == max_val SHALL set q to 0 and wrap=1 for exactly the following cycle.
REQ-018 en=1, up=0, 0 < q <= max_val SHALL set q to q-1; wrap=0.
REQ-019 en=1, up=0, q == 0 SHALL set q to max_val and wrap=1 for the following cycle.
REQ-020 If max_val is lowered below current q: en=1, up=1 SHALL set q to 0 with wrap=1; en=1, up=0 SHALL set q to max_val with wrap=0.
REQ-021 max_val == 0 SHALL hold q at 0; every enabled step SHALL pulse wrap.
REQ-022 en=0 and load=0 SHALL hold q; wrap SHALL be 0 the next cycle.
REQ-023 Arithmetic SHALL be WIDTH bits, no carry-out beyond wrap; WIDTH=32 with max_val=all-ones SHALL behave as a free-running modulo-2^32 counter.
REQ-024 wrap SHALL never be asserted two consecutive cycles unless two consecutive enabled wrapping steps occur.

Reset
REQ-025 clr=1 at a rising edge SHALL set q=RESET_VAL and wrap=0 next cycle, regardless of en, load, up.
REQ-026 clr asserted mid-count SHALL abort any pending wrap pulse; no wrap after reset release unless caused by a post-reset step.
REQ-027 Before first clr, q and wrap SHALL be treated as undefined; the bench SHALL apply clr first.

Configuration
REQ-028 Macro COUNTER_SAT_EN SHALL select saturation mode when defined.
REQ-029 With COUNTER_SAT_EN defined: up at q >= max_val SHALL set q to max_val, down at q == 0 SHALL hold 0, wrap SHALL be tied 0; all other rules unchanged.
REQ-030 Without COUNTER_SAT_EN: wrap-around behaviour per REQ-017..REQ-021.

Verification (WIDTH=4, RESET_VAL=0 unless stated)
REQ-031 clr=1 one cycle, max_val=9, en=1 up=1 for 10 cycles -> q 1..9 then 0; wrap=1 only in cycle after q 9->0; is_max=1 while q=9.
REQ-032 max_val=9, q=0, en=1 up=0 one cycle -> q=9, wrap=1 next cycle; further step -> q=8, wrap=0.
REQ-033 load=1 load_val=12 max_val=9 with en=1 same cycle -> q=9, wrap=0 (load wins, clamped).
REQ-034 q=7, max_val changed to 5, en=1 up=1 -> q=0, wrap=1; repeat with up=0 from q=7 -> q=5, wrap=0.
REQ-035 q=9 max_val=9, en=1 up=1 with clr=1 same cycle -> q=0, wrap=0 next cycle (RESET_VAL=3 variant -> q=3).
REQ-036 COUNTER_SAT_EN build, max_val=15: 20 up steps from 0 -> q stays 15, wrap never 1; 20 down steps -> q stays 0, is_all_zero=1.
